// File: rtl/regfile_dump_ctrl.sv
// Debug controller for a register file: streams registers 0..Depth-1 out over a
// valid/ready interface, and performs single debug writes when idle.
module regfile_dump_ctrl #(
    parameter int Depth = 32,
    parameter int Width = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             wr_req,
    input  logic [4:0]       wr_addr,
    input  logic [Width-1:0] wr_data,
    output logic [4:0]       rf_addr,
    input  logic [Width-1:0] rf_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [Width-1:0] rf_wdata,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic [4:0]       out_index,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             wr_ack
);
    localparam logic [4:0] LastIdx = 5'(Depth - 1);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t     state, state_nxt;
    logic [4:0] idx, idx_nxt;
    logic       wr_go;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rf_addr   = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        wr_go     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // start has priority; a simultaneous write request is dropped
                if (start) begin
                    idx_nxt   = '0;
                    state_nxt = READ;
                end else begin
                    wr_go = wr_req;
                end
            end
            READ: begin
                rf_addr   = idx;
                state_nxt = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx == LastIdx) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 5'd1;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            rf_we     <= 1'b0;
            wr_ack    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            rf_we  <= wr_go;
            wr_ack <= wr_go;
            if (wr_go) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
            // beat registers hold through SEND, so stalls keep the payload stable
            if (state == READ) begin
                out_data  <= rf_rdata;
                out_index <= idx;
                out_last  <= (idx == LastIdx);
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: beat-queue model checked every cycle, plus
// directed scenarios with hand-computed expectations (Depth=32 and Depth=4).
module tb_regfile_dump_ctrl;
    localparam int D = 32;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        CLK = 1'b0;
    logic        reset, start, wr_req, out_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rf_addr, rf_waddr, out_index;
    logic [31:0] rf_rdata, rf_wdata, out_data;
    logic        rf_we, out_valid, out_last, busy, done, wr_ack;

    logic        start4;
    logic        out_ready4 = 1'b1;
    logic        zero1 = 1'b0;
    logic [4:0]  zero5 = '0;
    logic [31:0] zero32 = '0;
    logic [4:0]  rf_addr4, rf_waddr4, out_index4;
    logic [31:0] rf_rdata4, rf_wdata4, out_data4;
    logic        rf_we4, out_valid4, out_last4, busy4, done4, wr_ack4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    regfile_dump_ctrl #(.Depth(D), .Width(32)) dut (
        .CLK(CLK), .reset(reset), .start(start), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .rf_addr(rf_addr),
        .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .out_valid(out_valid), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .wr_ack(wr_ack)
    );

    regfile_dump_ctrl #(.Depth(4), .Width(32)) dut4 (
        .CLK(CLK), .reset(reset), .start(start4), .wr_req(zero1),
        .wr_addr(zero5), .wr_data(zero32), .rf_addr(rf_addr4),
        .rf_rdata(rf_rdata4), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
        .rf_wdata(rf_wdata4), .out_valid(out_valid4), .out_data(out_data4),
        .out_index(out_index4), .out_last(out_last4), .out_ready(out_ready4),
        .busy(busy4), .done(done4), .wr_ack(wr_ack4)
    );

    // Register file seen by the DUT; preloaded with 0x100+i whenever reset is high.
    logic [31:0] rf [32];
    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata  = rf[rf_addr];
    assign rf_rdata4 = 32'h200 + {27'd0, rf_addr4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: a dump is a queue of beats; each beat costs one fetch
    // cycle then is offered until accepted; one done cycle follows the last beat.
    logic [31:0] model_rf [32];
    beat_t       exp_q[$];
    beat_t       f;
    bit          busy_m = 0, read_m = 0, done_m = 0, we_m = 0, v_exp, nxt_done, nxt_we;
    logic [4:0]  we_addr_m;
    logic [31:0] we_data_m;

    beat_t got[$];
    int    idx3_cnt = 0;
    int    we_seen  = 0;
    beat_t got4[$];

    always @(negedge CLK) begin
        v_exp = busy_m && !read_m && (exp_q.size() > 0);
        if (chk_en) begin
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            chk("rf_we", rf_we, we_m);
            chk("wr_ack", wr_ack, we_m);
            if (we_m) begin
                chk("rf_waddr", rf_waddr, we_addr_m);
                chk("rf_wdata", rf_wdata, we_data_m);
            end
            chk("out_valid", out_valid, v_exp);
            if (v_exp) begin
                chk("out_index", out_index, exp_q[0].idx);
                chk("out_data", out_data, exp_q[0].data);
                chk("out_last", out_last, exp_q[0].last);
            end
            if (busy_m && read_m && exp_q.size() > 0) chk("rf_addr_read", rf_addr, exp_q[0].idx);
            else chk("rf_addr_zero", rf_addr, 0);
            if (out_valid && out_ready) got.push_back('{idx: out_index, data: out_data, last: out_last});
            if (out_valid && out_index == 5'd3) idx3_cnt++;
            if (rf_we || wr_ack) we_seen++;
        end
        if (reset) begin
            busy_m = 0; read_m = 0; done_m = 0; we_m = 0;
            exp_q.delete();
            for (int i = 0; i < 32; i++) model_rf[i] = 32'h100 + i;
        end else begin
            nxt_done = 0;
            nxt_we   = 0;
            if (!busy_m && start) begin
                busy_m = 1;
                read_m = 1;
                for (int i = 0; i < D; i++)
                    exp_q.push_back('{idx: 5'(i), data: model_rf[i], last: (i == D - 1)});
            end else if (!busy_m && wr_req) begin
                nxt_we    = 1;
                we_addr_m = wr_addr;
                we_data_m = wr_data;
                model_rf[wr_addr] = wr_data;
            end else if (done_m) begin
                busy_m = 0;
            end else if (v_exp && out_ready) begin
                f = exp_q.pop_front();
                if (exp_q.size() > 0) read_m = 1;
                else nxt_done = 1;
            end else if (read_m) begin
                read_m = 0;
            end
            done_m = nxt_done;
            we_m   = nxt_we;
        end
    end

    always @(negedge CLK)
        if (out_valid4 && out_ready4) got4.push_back('{idx: out_index4, data: out_data4, last: out_last4});

    task automatic do_start(output int t0);
        @(posedge CLK); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int c);
        c = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (done) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idx(input logic [4:0] k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_index == k) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0, c, gb, b;
        bit  ok;
        reset = 1; start = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
        out_ready = 1; start4 = 0;
        repeat (2) @(posedge CLK);
        #1;
        reset  = 0;
        chk_en = 1;

        // reset state
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);

        // full dump, with a stray start+write mid-dump that must be ignored
        gb = got.size();
        do_start(t0);
        repeat (10) @(posedge CLK);
        #1;
        start = 1; wr_req = 1; wr_addr = 5'd3; wr_data = 32'h0BAD;
        @(posedge CLK); #1;
        start = 0; wr_req = 0;
        wait_done(200, c);
        chk("full_done_latency", c - t0, 65);
        chk("full_beats", got.size() - gb, 32);
        chk("full_first_data", got[gb].data, 32'h100);
        chk("full_idx3_data", got[gb+3].data, 32'h103);
        chk("full_last_idx", got[gb+31].idx, 31);
        chk("full_last_data", got[gb+31].data, 32'h11F);
        chk("full_last_flag", got[gb+31].last, 1);
        chk("full_prelast_flag", got[gb+30].last, 0);

        // backpressure for 5 cycles on index 3
        gb = got.size();
        b  = idx3_cnt;
        do_start(t0);
        wait_idx(5'd3, ok);
        chk("bp_reach_idx3", ok, 1);
        out_ready = 0;
        repeat (5) begin @(posedge CLK); #1; end
        out_ready = 1;
        wait_done(200, c);
        chk("bp_done_latency", c - t0, 70);
        chk("bp_idx3_cycles", idx3_cnt - b, 6);
        chk("bp_beats", got.size() - gb, 32);
        chk("bp_idx4_follows", got[gb+4].idx, 4);

        // debug write then dump
        @(posedge CLK); #1;
        wr_req = 1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        @(posedge CLK); #1;
        wr_req = 0;
        @(negedge CLK);
        chk("wr_rf_we", rf_we, 1);
        chk("wr_ack_pulse", wr_ack, 1);
        chk("wr_waddr", rf_waddr, 7);
        chk("wr_wdata", rf_wdata, 32'hDEADBEEF);
        @(negedge CLK);
        chk("wr_rf_we_off", rf_we, 0);
        chk("wr_ack_off", wr_ack, 0);
        gb = got.size();
        do_start(t0);
        wait_done(200, c);
        chk("wr_dump_idx7", got[gb+7].data, 32'hDEADBEEF);
        chk("wr_dump_idx6", got[gb+6].data, 32'h106);

        // start and write together: start wins
        b  = we_seen;
        gb = got.size();
        @(posedge CLK); #1;
        start = 1; wr_req = 1; wr_addr = 5'd9; wr_data = 32'h12345678;
        t0 = cyc;
        @(posedge CLK); #1;
        start = 0; wr_req = 0;
        wait_done(200, c);
        chk("sw_done_latency", c - t0, 65);
        chk("sw_no_write", we_seen - b, 0);
        chk("sw_idx9_data", got[gb+9].data, 32'h109);

        // reset in SEND at index 10 aborts the dump
        do_start(t0);
        wait_idx(5'd10, ok);
        chk("rst_reach_idx10", ok, 1);
        reset = 1;
        @(posedge CLK); #1;
        reset = 0;
        @(negedge CLK);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        wait_done(80, c);
        chk("abort_no_done", c, 32'hFFFF_FFFF);
        gb = got.size();
        do_start(t0);
        wait_done(200, c);
        chk("restart_latency", c - t0, 65);
        chk("restart_first_idx", got[gb].idx, 0);
        chk("restart_beats", got.size() - gb, 32);

        // write request coinciding with reset is dropped
        @(posedge CLK); #1;
        wr_req = 1; wr_addr = 5'd5; wr_data = 32'hCAFE;
        reset = 1;
        @(posedge CLK); #1;
        wr_req = 0; reset = 0;
        @(negedge CLK);
        chk("rstwr_rf_we", rf_we, 0);
        chk("rstwr_wr_ack", wr_ack, 0);

        // Depth=4 instance
        @(posedge CLK); #1;
        start4 = 1;
        t0 = cyc;
        @(posedge CLK); #1;
        start4 = 0;
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (done4) begin
                c = cyc;
                break;
            end
        end
        chk("d4_done_latency", c - t0, 9);
        chk("d4_beats", got4.size(), 4);
        chk("d4_first_idx", got4[0].idx, 0);
        chk("d4_last_idx", got4[3].idx, 3);
        chk("d4_last_data", got4[3].data, 32'h203);
        chk("d4_last_flag", got4[3].last, 1);
        chk("d4_prelast_flag", got4[2].last, 0);

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 The block SHALL have parameter Depth, default 32, meaning number of registers scanned (2..32).
REQ-002 The block SHALL have parameter Width, default 32, meaning register data width in bits.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on rising CLK.
REQ-005 The block SHALL have port start, input, 1, request to dump registers 0..Depth-1.
REQ-006 The block SHALL have port wr_req, input, 1, debug write request.
REQ-007 The block SHALL have port wr_addr, input, 5, debug write register index.
REQ-008 The block SHALL have port wr_data, input, Width, debug write data.
REQ-009 The block SHALL have port rf_addr, output, 5, register-file read address, driving A1.
REQ-010 The block SHALL have port rf_rdata, input, Width, combinational register-file read data from RD1.
REQ-011 The block SHALL have ports rf_we (1), rf_waddr (5) and rf_wdata (Width), all outputs, driving WE3, A3 and WD3.
REQ-012 The block SHALL have ports out_valid, out_data (Width), out_index (5) and out_last, all outputs, forming the dump stream.
REQ-013 The block SHALL have port out_ready, input, 1, stream consumer ready.
REQ-014 The block SHALL have ports busy, done and wr_ack, all outputs, 1 bit each, reporting status.

Function
REQ-015 FSM states SHALL be IDLE, READ, SEND and DONE, with 5-bit index register idx.
REQ-016 In IDLE, start=1 SHALL set idx=0 and move to READ next cycle.
REQ-017 In READ, rf_addr SHALL equal idx; out_data<=rf_rdata, out_index<=idx, out_last<=(idx==Depth-1); next state SHALL be SEND.
REQ-018 In SEND, out_valid SHALL be 1 and out_data, out_index and out_last SHALL be held stable until out_valid&&out_ready.
REQ-019 On a SEND handshake with idx<Depth-1, idx SHALL increment by 1 and the next state SHALL be READ.
REQ-020 On a SEND handshake with idx==Depth-1, the next state SHALL be DONE; idx SHALL never wrap past Depth-1.
REQ-021 DONE SHALL last exactly one cycle, with done=1 in that cycle, then return to IDLE.
REQ-022 Latency SHALL be 2 cycles from start to the first out_valid; each element after that SHALL take 2 cycles minimum; a full dump with out_ready held 1 SHALL take 2*Depth+1 cycles from start to done.
REQ-023 busy SHALL be 1 in READ, SEND and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored when not in IDLE.
REQ-025 In IDLE with wr_req=1 and start=0, the block SHALL register wr_addr and wr_data, then assert rf_we=1 and wr_ack=1 for exactly one cycle next cycle, with rf_waddr and rf_wdata equal to the captured values.
REQ-026 If start=1 and wr_req=1 arrive together in IDLE, start SHALL win, no write SHALL occur, and wr_ack SHALL stay 0.
REQ-027 wr_req outside IDLE SHALL be ignored, with no write and no ack.
REQ-028 rf_we SHALL never be 1 while busy=1.
REQ-029 rf_addr SHALL be 0 whenever not in READ.
REQ-030 Register 0 SHALL be streamed as read, with no forced zero.

Reset
REQ-031 When reset=1 at a rising CLK edge, the FSM SHALL enter IDLE and idx SHALL be 0.
REQ-032 When reset=1 at a rising CLK edge, out_valid, out_last, busy, done, rf_we and wr_ack SHALL be 0.
REQ-033 When reset=1 at a rising CLK edge, out_data, rf_wdata, out_index and rf_waddr SHALL be 0.
REQ-034 Reset mid-dump SHALL abort the dump with no done pulse, and the next start SHALL restart from index 0.
REQ-035 A pending debug write SHALL be dropped on reset, with rf_we 0 in the cycle after reset.

Verification
REQ-036 Preload reg i = 0x100+i, start pulse, out_ready=1 -> 32 beats, index 0..31, data 0x100..0x11F, out_last only on index 31, done at cycle 65.
REQ-037 Backpressure: out_ready=0 for 5 cycles at index 3 -> out_valid held 1, out_data 0x103 stable, no skipped or duplicate index.
REQ-038 wr_req with addr=7 and data=0xDEADBEEF in IDLE -> next cycle rf_we=1, rf_waddr=7, wr_ack=1 for one cycle; the following dump shows index 7 = 0xDEADBEEF.
REQ-039 start and wr_req in the same cycle -> dump starts, rf_we stays 0 throughout, wr_ack=0.
REQ-040 reset asserted at index 10 during SEND -> next cycle out_valid=0 and busy=0, done never pulses; a new start streams from index 0.
REQ-041 Depth=4 build -> 4 beats, out_last on index 3, done 9 cycles after start.
